// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch control. Owns the PC and keeps at most one instruction-memory
//   request outstanding. Redirects move the PC and flush the output buffer. A
//   response to a request that a redirect made wrong-path is dropped.
//   Each fetched instruction goes to decode through a one-entry valid/ready buffer.
//
//   Build option: define FETCH_PERF_CNT_EN to build the perf_fetched / perf_stall
//   counters. Without it, no counter registers exist and both ports read 0.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   redirect, redirect_addr  one-cycle jump request and its word-index target
//   imem_req, imem_addr      one-cycle request pulse to instruction memory, and its address
//   imem_rvalid, imem_rdata  one-cycle response strobe and its data
//   if_valid, if_ready       output-buffer handshake with decode
//   if_instr, if_pc          buffered instruction and its PC
//   if_pc_next               if_pc + 1, wrapping
//   perf_fetched, perf_stall delivered-instruction and stall-cycle counters
module fetch_sequencer #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic [AW-1:0] if_pc_next,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          discard;  // the outstanding response is wrong-path
  logic          xfer;

  assign xfer       = if_valid && if_ready;
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc;
  assign if_pc_next = if_pc + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= RESET_PC;
    end else if (redirect) begin
      // A redirect overrides every other event in the same cycle.
      pc       <= redirect_addr;
      if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          // The request going out this cycle is already wrong-path.
          discard <= 1'b1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            // The pending response arrives now and is dropped, so no later
            // response needs to be dropped.
            discard <= 1'b0;
            state   <= S_REQ;
          end else begin
            discard <= 1'b1;
          end
        end
        default: state <= S_REQ;  // S_HOLD: any same-cycle transfer has already happened
      endcase
    end else begin
      case (state)
        S_REQ: state <= S_WAIT;  // a late response seen here is a stray and is ignored
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + AW'(1);
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (xfer) begin
            if_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (xfer)                  fetched_q <= fetched_q + 32'd1;
      if (if_valid && !if_ready) stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. All stimulus and sampling happens on the
// falling clock edge, and the memory is modelled by hand inside each task.
module tb_fetch_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_next;
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
    .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %h required 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h required 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", if_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
    checks++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin errors++; $display("FAIL rst_perf: got %h/%h required 0/0", perf_fetched, perf_stall); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got %b/%h required 1/0", imem_req, imem_addr); end
  endtask

  // 1-cycle memory, data = addr+4, three back-to-back instructions.
  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(k)) begin errors++; $display("FAIL seq_req%0d: got %b/%h required 1/%h", k, imem_req, imem_addr, k); end
      @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'(k + 4);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait%0d: got req %b required 0", k, imem_req); end
      @(negedge clk); imem_rvalid = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'(k + 4) || if_pc !== 32'(k)) begin errors++; $display("FAIL seq_out%0d: got %b/%h/%h required 1/%h/%h", k, if_valid, if_instr, if_pc, k + 4, k); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_hold%0d: got req %b required 0", k, imem_req); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    if_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd3) begin errors++; $display("FAIL stall_req: got %b/%h required 1/3", imem_req, imem_addr); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'd7;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'd7) begin errors++; $display("FAIL stall_first: got %b/%h required 1/7", if_valid, if_instr); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'd7 || if_pc !== 32'd3 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got %b/%h/%h/%b required 1/7/3/0", i, if_valid, if_instr, if_pc, imem_req); end
    end
    checks++; if (perf_stall !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stall_cnt: got %0d required %0d", perf_stall, PERF ? 5 : 0); end
    checks++; if (perf_fetched !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL fetched_cnt3: got %0d required %0d", perf_fetched, PERF ? 3 : 0); end
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL stall_release: got %b/%b/%h required 0/1/4", if_valid, imem_req, imem_addr); end
    checks++; if (perf_fetched !== (PERF ? 32'd4 : 32'd0)) begin errors++; $display("FAIL fetched_cnt4: got %0d required %0d", perf_fetched, PERF ? 4 : 0); end
  endtask

  // Redirect while waiting on a 3-cycle response; the stale response must vanish.
  task automatic test_redirect_wait();
    @(negedge clk); redirect = 1'b1; redirect_addr = 32'h40;
    @(negedge clk); redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rw_wait: got %b/%b required 0/0", imem_req, if_valid); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'hdead;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rw_drop: got %b/%b/%h required 0/1/40", if_valid, imem_req, imem_addr); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'h44;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h44) begin errors++; $display("FAIL rw_out: got %b/%h/%h required 1/40/44", if_valid, if_pc, if_instr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h41) begin errors++; $display("FAIL rw_next: got %b/%h required 1/41", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_rvalid();
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'h45; redirect = 1'b1; redirect_addr = 32'h80;
    @(negedge clk); imem_rvalid = 1'b0; redirect = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL rr_req: got %b/%b/%h required 0/1/80", if_valid, imem_req, imem_addr); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'h84;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== 32'h84) begin errors++; $display("FAIL rr_out: got %b/%h/%h required 1/80/84", if_valid, if_pc, if_instr); end
    @(negedge clk);
  endtask

  // Redirect in S_REQ to the top address; the in-flight response is wrong-path.
  task automatic test_wrap();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h81) begin errors++; $display("FAIL wr_req: got %b/%h required 1/81", imem_req, imem_addr); end
    redirect = 1'b1; redirect_addr = 32'hffff_ffff;
    @(negedge clk); redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hbad;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hffff_ffff) begin errors++; $display("FAIL wr_top: got %b/%b/%h required 0/1/ffffffff", if_valid, imem_req, imem_addr); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'h1234;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hffff_ffff || if_instr !== 32'h1234) begin errors++; $display("FAIL wr_out: got %b/%h/%h required 1/ffffffff/1234", if_valid, if_pc, if_instr); end
    checks++; if (if_pc_next !== 32'h0) begin errors++; $display("FAIL wr_pc_next: got %h required 0", if_pc_next); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_wrap: got %b/%h required 1/0", imem_req, imem_addr); end
  endtask

  // Transfer and redirect in the same S_HOLD cycle.
  task automatic test_hold_redirect();
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'h55;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h55) begin errors++; $display("FAIL hr_out: got %b/%h required 1/55", if_valid, if_instr); end
    redirect = 1'b1; redirect_addr = 32'h10;
    @(negedge clk); redirect = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL hr_req: got %b/%b/%h required 0/1/10", if_valid, imem_req, imem_addr); end
    checks++; if (perf_fetched !== (PERF ? 32'd8 : 32'd0)) begin errors++; $display("FAIL fetched_cnt8: got %0d required %0d", perf_fetched, PERF ? 8 : 0); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mr_rst: got %b/%h/%h/%h required 0/0/0/0", if_valid, if_instr, if_pc, imem_addr); end
    checks++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin errors++; $display("FAIL mr_perf: got %h/%h required 0/0", perf_fetched, perf_stall); end
    @(negedge clk); rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h99;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mr_req: got %b/%h required 1/0", imem_req, imem_addr); end
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mr_stray: got %b/%b required 0/0", if_valid, imem_req); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'h4;
    @(negedge clk); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h4 || if_pc !== 32'h0) begin errors++; $display("FAIL mr_out: got %b/%h/%h required 1/4/0", if_valid, if_instr, if_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_hold_redirect();
    test_reset_midflight();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage. Owns the PC register and issues one instruction-memory request at a time.
- Applies branch/jump redirects, including squashing any in-flight wrong-path response.
- Presents each fetched instruction to decode through a one-entry valid/ready output buffer.
- Sits between the branch-resolution logic (redirect source), the instruction memory (variable latency, at least 1 cycle) and the decode stage.

Parameters:
- AW, 32, PC width in bits; the PC is a word index, so the next sequential PC is pc+1.
- DW, 32, instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- redirect  input  1  one-cycle pulse; the PC must jump to redirect_addr.
- redirect_addr  input  AW  redirect target (word index).
- imem_req  output  1  one-cycle request pulse to instruction memory.
- imem_addr  output  AW  request address; valid while imem_req=1.
- imem_rvalid  input  1  one-cycle response strobe; at most one per request, at least 1 cycle after imem_req.
- imem_rdata  input  DW  response data; valid with imem_rvalid.
- if_valid  output  1  output buffer holds a valid instruction.
- if_ready  input  1  decode accepts the instruction; a transfer occurs when if_valid && if_ready.
- if_instr  output  DW  buffered instruction.
- if_pc  output  AW  PC of if_instr.
- if_pc_next  output  AW  if_pc+1, combinational, wraps modulo 2^AW.
- perf_fetched  output  32  count of delivered instructions (optional feature).
- perf_stall  output  32  count of cycles with if_valid && !if_ready (optional feature).

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD. The reset state is S_REQ.
- Reset values (async assert, sync release): pc=RESET_PC, discard=0, if_valid=0, if_instr=0, if_pc=RESET_PC, perf counters=0.
- imem_req = (state==S_REQ), decoded only from registered state. imem_addr = pc.
- The first imem_req occurs in the first clock after rst_n deasserts.
- S_REQ: the request is issued this cycle; next state is S_WAIT.
- S_WAIT on imem_rvalid with discard=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1, next state S_HOLD.
- S_WAIT on imem_rvalid with discard=1: drop the data, discard<=0, next state S_REQ.
- S_WAIT with no imem_rvalid: stay in S_WAIT indefinitely. There is no timeout.
- S_HOLD on if_valid && if_ready: if_valid<=0, next state S_REQ. Otherwise hold; if_instr and if_pc stay stable.
- Latency: imem_req to if_valid is memory latency + 1. Sustained throughput with 1-cycle memory is one instruction per 3 cycles.
- At most one outstanding request. No request is issued while the buffer is full.
- Redirect takes priority over every other event in the same cycle:
  - Always: pc<=redirect_addr and if_valid<=0 (flush).
  - In S_REQ: the request issued this cycle is wrong-path, so discard<=1 and next state is S_WAIT.
  - In S_WAIT without imem_rvalid: discard<=1; stay in S_WAIT.
  - In S_WAIT with imem_rvalid the same cycle: drop the data, discard<=0, next state S_REQ.
  - In S_HOLD: next state S_REQ. If a transfer also fires that cycle, decode has taken the instruction, but the flush still applies.
- A second redirect while discard=1 updates pc only; discard stays 1, and exactly one response is dropped.
- PC increment wraps: pc=2^AW-1 is followed by 0.
- Reset asserted mid-transaction returns all state to reset values immediately. A late imem_rvalid arriving in S_REQ is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: perf_fetched increments on each transfer; perf_stall increments on each cycle with if_valid && !if_ready. Both are 32-bit wrapping counters, cleared only by rst_n.
- When undefined: no counter registers are built, and both ports are tied to 0.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory returning data=addr+4, if_ready=1 -> imem_addr 0,1,2 on cycles 1,4,7; if_instr 4,5,6 with if_pc 0,1,2.
- Hold if_ready=0 for 5 cycles after the first instruction -> if_valid stays 1, if_instr=4 stable, no imem_req; with the macro on, perf_stall=5.
- Redirect to 0x40 while in S_WAIT (3-cycle memory) -> the old response is dropped, if_valid never asserts for it, next imem_addr=0x40, and the next delivered if_pc=0x40.
- Redirect in the same cycle as imem_rvalid -> the data is dropped, and imem_req to redirect_addr comes on the next cycle.
- Set pc to 2^AW-1 via redirect -> if_pc_next=0, and the following imem_addr=0.
- Assert rst_n low during S_WAIT, then deliver imem_rvalid -> outputs are at reset values, the response is ignored, and fetch restarts at RESET_PC.
